// File: rtl/sa_driver.sv
// Initiator for the systolic array: buffers one A/W operand tile plus a bias tile, replays them skewed, captures and drains results.
// No arithmetic; strobes are gap-free, load and drain use valid/ready, WAIT and CAP abort with err_o.
module sa_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int INTER_NUM  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 start_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    input  logic                                 op_valid_i,
    output logic                                 op_ready_o,
    input  logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   op_a_i,
    input  logic [COL_NUM-1:0][DATA_WIDTH-1:0]   op_w_i,
    input  logic                                 bias_valid_i,
    output logic                                 bias_ready_o,
    input  logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   bias_col_i,
    output logic                                 sa_iv_o,
    output logic                                 sa_mac_iv_o,
    output logic                                 sa_bias_iv_o,
    output logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   sa_row_a_o,
    output logic [COL_NUM-1:0][DATA_WIDTH-1:0]   sa_col_w_o,
    output logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   sa_bias_col_o,
    input  logic                                 sa_ov_i,
    input  logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   sa_psum_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [ROW_NUM-1:0][DATA_WIDTH-1:0]   res_col_o,
    output logic [$clog2(COL_NUM)-1:0]           res_idx_o
);

    localparam int F  = INTER_NUM + ROW_NUM + COL_NUM - 2;
    localparam int FW = $clog2(F);
    localparam int KW = $clog2(INTER_NUM);
    localparam int CW = $clog2(COL_NUM);
    localparam int TW = $clog2(TIMEOUT);

    typedef logic [ROW_NUM-1:0][DATA_WIDTH-1:0] rowv_t;
    typedef logic [COL_NUM-1:0][DATA_WIDTH-1:0] colv_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FEED, S_BIAS, S_WAIT, S_CAP, S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  op_cnt;
    logic           op_done;
    logic [CW-1:0]  bl_cnt;
    logic           bl_done;
    logic [FW-1:0]  feed_cnt;
    logic [CW-1:0]  bias_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [CW-1:0]  cap_cnt;
    logic [CW-1:0]  res_idx;

    rowv_t a_buf [INTER_NUM];
    colv_t w_buf [INTER_NUM];
    rowv_t b_buf [COL_NUM];
    rowv_t r_buf [COL_NUM];

    logic op_hs, op_last, op_fin;
    logic bl_hs, bl_last, bl_fin;
    logic res_hs, res_last;

    assign op_hs    = op_ready_o & op_valid_i;
    assign op_last  = op_hs & (op_cnt == KW'(INTER_NUM - 1));
    assign op_fin   = op_done | op_last;
    assign bl_hs    = bias_ready_o & bias_valid_i;
    assign bl_last  = bl_hs & (bl_cnt == CW'(COL_NUM - 1));
    assign bl_fin   = bl_done | bl_last;
    assign res_hs   = res_valid_o & res_ready_i;
    assign res_last = res_hs & (res_idx == CW'(COL_NUM - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  if (op_fin && bl_fin) state_d = S_FEED;
            S_FEED:  if (feed_cnt == FW'(F - 1)) state_d = S_BIAS;
            S_BIAS:  if (bias_cnt == CW'(COL_NUM - 1)) state_d = S_WAIT;
            S_WAIT: begin
                if (sa_ov_i) begin
                    state_d = S_CAP;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    err_o   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CAP: begin
                // the burst must be contiguous; a gap means the array lost sync
                if (!sa_ov_i) begin
                    err_o   = 1'b1;
                    state_d = S_IDLE;
                end else if (cap_cnt == CW'(COL_NUM - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_last) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        op_ready_o    = (state_q == S_LOAD) & ~op_done;
        bias_ready_o  = (state_q == S_LOAD) & ~bl_done;
        sa_iv_o       = (state_q == S_FEED) | (state_q == S_BIAS) |
                        (state_q == S_WAIT) | (state_q == S_CAP);
        sa_mac_iv_o   = (state_q == S_FEED);
        sa_bias_iv_o  = (state_q == S_BIAS);
        res_valid_o   = (state_q == S_DRAIN);
        res_idx_o     = res_idx;
        sa_bias_col_o = '0;
        res_col_o     = '0;
        if (state_q == S_BIAS)  sa_bias_col_o = b_buf[bias_cnt];
        if (state_q == S_DRAIN) res_col_o     = r_buf[res_idx];
    end

    // Diagonal skew: row m / column n lag the feed counter by m / n cycles.
    always_comb begin : skew
        int ka;
        int kw;
        ka         = 0;
        kw         = 0;
        sa_row_a_o = '0;
        sa_col_w_o = '0;
        if (state_q == S_FEED) begin
            for (int m = 0; m < ROW_NUM; m++) begin
                ka = int'(feed_cnt) - m;
                if (ka >= 0 && ka < INTER_NUM) sa_row_a_o[m] = a_buf[KW'(ka)][m];
            end
            for (int n = 0; n < COL_NUM; n++) begin
                kw = int'(feed_cnt) - n;
                if (kw >= 0 && kw < INTER_NUM) sa_col_w_o[n] = w_buf[KW'(kw)][n];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_cnt   <= '0;
            op_done  <= 1'b0;
            bl_cnt   <= '0;
            bl_done  <= 1'b0;
            feed_cnt <= '0;
            bias_cnt <= '0;
            wait_cnt <= '0;
            cap_cnt  <= '0;
            res_idx  <= '0;
            for (int i = 0; i < INTER_NUM; i++) begin
                a_buf[i] <= '0;
                w_buf[i] <= '0;
            end
            for (int i = 0; i < COL_NUM; i++) begin
                b_buf[i] <= '0;
                r_buf[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    op_cnt   <= '0;
                    op_done  <= 1'b0;
                    bl_cnt   <= '0;
                    bl_done  <= 1'b0;
                    feed_cnt <= '0;
                    bias_cnt <= '0;
                    wait_cnt <= '0;
                    cap_cnt  <= '0;
                    res_idx  <= '0;
                end
                S_LOAD: begin
                    if (op_hs) begin
                        a_buf[op_cnt] <= op_a_i;
                        w_buf[op_cnt] <= op_w_i;
                        if (op_last) op_done <= 1'b1;
                        else         op_cnt  <= op_cnt + KW'(1);
                    end
                    if (bl_hs) begin
                        b_buf[bl_cnt] <= bias_col_i;
                        if (bl_last) bl_done <= 1'b1;
                        else         bl_cnt  <= bl_cnt + CW'(1);
                    end
                end
                S_FEED: begin
                    if (feed_cnt != FW'(F - 1)) feed_cnt <= feed_cnt + FW'(1);
                end
                S_BIAS: begin
                    if (bias_cnt != CW'(COL_NUM - 1)) bias_cnt <= bias_cnt + CW'(1);
                end
                S_WAIT: begin
                    if (sa_ov_i) begin
                        r_buf[0] <= sa_psum_i;
                        cap_cnt  <= CW'(1);
                    end else if (wait_cnt != TW'(TIMEOUT - 1)) begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_CAP: begin
                    if (sa_ov_i) begin
                        r_buf[cap_cnt] <= sa_psum_i;
                        if (cap_cnt != CW'(COL_NUM - 1)) cap_cnt <= cap_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (res_hs) begin
                        if (res_last) res_idx <= '0;
                        else          res_idx <= res_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_driver.sv
// Directed bench for sa_driver: vector table for skew/bias replay plus sequences for load, timeout, drain stall and reset.
module tb_sa_driver;
    localparam int DW = 8;
    localparam int RN = 8;
    localparam int CN = 8;
    localparam int IN = 8;

    typedef logic [RN-1:0][DW-1:0] rowv_t;
    typedef logic [CN-1:0][DW-1:0] colv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, start_i, busy_o, done_o, err_o;
    logic op_valid_i, op_ready_o, bias_valid_i, bias_ready_o;
    rowv_t op_a_i, bias_col_i, sa_row_a_o, sa_bias_col_o, sa_psum_i, res_col_o;
    colv_t op_w_i, sa_col_w_o;
    logic sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, sa_ov_i, res_valid_o, res_ready_i;
    logic [2:0] res_idx_o;

    sa_driver #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN), .INTER_NUM(IN), .TIMEOUT(64)) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_w_i(op_w_i),
        .bias_valid_i(bias_valid_i), .bias_ready_o(bias_ready_o), .bias_col_i(bias_col_i),
        .sa_iv_o(sa_iv_o), .sa_mac_iv_o(sa_mac_iv_o), .sa_bias_iv_o(sa_bias_iv_o),
        .sa_row_a_o(sa_row_a_o), .sa_col_w_o(sa_col_w_o), .sa_bias_col_o(sa_bias_col_o),
        .sa_ov_i(sa_ov_i), .sa_psum_i(sa_psum_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_col_o(res_col_o), .res_idx_o(res_idx_o)
    );

    logic any_out;
    assign any_out = busy_o | done_o | err_o | op_ready_o | bias_ready_o | sa_iv_o | sa_mac_iv_o |
                     sa_bias_iv_o | (|sa_row_a_o) | (|sa_col_w_o) | (|sa_bias_col_o) |
                     res_valid_o | (|res_col_o) | (|res_idx_o);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // operand tiles and the array model's result columns
    logic [7:0] A [RN][IN];
    logic [7:0] W [IN][CN];
    logic [7:0] B [RN][CN];
    logic [7:0] P [CN][RN];

    task automatic set_data(input int which);
        for (int m = 0; m < RN; m++)
            for (int k = 0; k < IN; k++)
                A[m][k] = (which == 0) ? ((m == k) ? 8'd1 : 8'd0) : 8'(16 * m + k + 1);
        for (int k = 0; k < IN; k++)
            for (int n = 0; n < CN; n++)
                W[k][n] = (which == 0) ? 8'(k + 1) : 8'(8'h40 + 8 * k + n);
        for (int m = 0; m < RN; m++)
            for (int c = 0; c < CN; c++)
                B[m][c] = (which == 0) ? 8'd0 : 8'(16 * c + m);
        for (int j = 0; j < CN; j++)
            for (int r = 0; r < RN; r++)
                P[j][r] = (which == 0) ? W[r][j] : 8'(8'hA0 + 8 * j + r);
    endtask

    // passive monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rowv_t fa [32];
    colv_t fw [32];
    rowv_t fb [16];
    int feed_pos = 0, feed_start = 0, bias_pos = 0, wait_run = 0;
    int done_total = 0, err_total = 0, both_total = 0, resv_total = 0;
    logic prev_mac = 1'b0, prev_bias = 1'b0;

    always @(negedge clk) begin
        if (sa_mac_iv_o) begin
            if (!prev_mac) begin
                feed_pos   = 0;
                feed_start = cyc;
            end
            if (feed_pos < 32) begin
                fa[feed_pos] = sa_row_a_o;
                fw[feed_pos] = sa_col_w_o;
            end
            feed_pos++;
        end
        if (sa_bias_iv_o) begin
            if (!prev_bias) bias_pos = 0;
            if (bias_pos < 16) fb[bias_pos] = sa_bias_col_o;
            bias_pos++;
            wait_run = 0;
        end else if (sa_iv_o && !sa_mac_iv_o) begin
            wait_run++;
        end
        prev_mac  = sa_mac_iv_o;
        prev_bias = sa_bias_iv_o;
        if (done_o) done_total++;
        if (err_o) err_total++;
        if (done_o && err_o) both_total++;
        if (res_valid_o) resv_total++;
    end

    task automatic run_load(input int mode, output int last_beat);
        int kops, kb, guard;
        bit op_ck, bl_ck;
        kops = 0; kb = 0; guard = 0; op_ck = 0; bl_ck = 0; last_beat = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while ((kops < IN || kb < CN) && guard < 100) begin
            op_valid_i   = (kops < IN) && (mode == 0 || cyc % 2 == 0);
            bias_valid_i = (kb < CN) && (mode == 0 || cyc % 2 == 1);
            for (int m = 0; m < RN; m++) op_a_i[m] = (kops < IN) ? A[m][kops] : 8'd0;
            for (int n = 0; n < CN; n++) op_w_i[n] = (kops < IN) ? W[kops][n] : 8'd0;
            for (int m = 0; m < RN; m++) bias_col_i[m] = (kb < CN) ? B[m][kb] : 8'd0;
            @(negedge clk);
            if (kops == IN && !op_ck) begin
                chk("op_ready_drop", op_ready_o, 1'b0);
                op_ck = 1;
            end
            if (kb == CN && !bl_ck) begin
                chk("bias_ready_drop", bias_ready_o, 1'b0);
                bl_ck = 1;
            end
            if (op_valid_i && op_ready_o) begin
                kops++;
                if (kops == IN) last_beat = cyc;
            end
            if (bias_valid_i && bias_ready_o) begin
                kb++;
                if (kb == CN) last_beat = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        chk("load_complete", (kops == IN) && (kb == CN), 1'b1);
        op_valid_i = 1'b0;
        bias_valid_i = 1'b0;
    endtask

    task automatic run_result(input int ov_delay, input int ov_beats, input int rdy_mode);
        int j, wcnt, guard, idx, i;
        bit seen, fell, stop;
        j = 0; wcnt = 0; guard = 0; seen = 0; fell = 0; stop = 0;
        while (!stop && guard < 300) begin
            sa_ov_i = (ov_beats > 0) && fell && (wcnt >= ov_delay) && (j < ov_beats);
            for (int r = 0; r < RN; r++) sa_psum_i[r] = (sa_ov_i && j < CN) ? P[j][r] : 8'hEE;
            @(negedge clk);
            if (sa_ov_i) begin
                if (j == 0) chk("sa_iv_in_cap", sa_iv_o, 1'b1);
                j++;
            end
            if (sa_bias_iv_o) seen = 1;
            else if (seen) fell = 1;
            if (fell && !sa_ov_i) wcnt++;
            stop = (ov_beats == 0) ? !busy_o : (j == ov_beats);
            @(posedge clk); #1;
            guard++;
        end
        chk("result_phase_bound", stop, 1'b1);
        sa_ov_i = 1'b0;
        sa_psum_i = '0;
        if (ov_beats == 0) return;
        if (ov_beats < CN) begin
            @(negedge clk);
            chk("cap_drop_err", err_o, 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("cap_drop_idle", busy_o, 1'b0);
            @(posedge clk); #1;
            return;
        end
        idx = 0; i = 0; guard = 0;
        while (idx < CN && guard < 100) begin
            res_ready_i = (rdy_mode == 0) ? 1'b1 : (i % 3 == 0);
            @(negedge clk);
            if (i == 0) chk("sa_iv_off_drain", sa_iv_o, 1'b0);
            chk("drain_valid", res_valid_o, 1'b1);
            chk($sformatf("drain_idx%0d", idx), res_idx_o, idx[2:0]);
            chk($sformatf("drain_col%0d", idx), res_col_o, {P[idx][7], P[idx][6], P[idx][5], P[idx][4],
                                                             P[idx][3], P[idx][2], P[idx][1], P[idx][0]});
            chk("done_timing", done_o, res_ready_i && idx == CN - 1);
            if (res_ready_i) idx++;
            i++;
            @(posedge clk); #1;
            guard++;
        end
        res_ready_i = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {busy_o, res_valid_o}, 2'b00);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int         job;
        int         kind;   // 0 = row A, 1 = column W, 2 = bias column
        int         t;
        int         lane;
        logic [7:0] exp;
    } vec_t;

    vec_t tv [20];

    task automatic apply_table(input int job);
        logic [7:0] act;
        for (int i = 0; i < 20; i++) begin
            if (tv[i].job == job) begin
                case (tv[i].kind)
                    0:       act = fa[tv[i].t][tv[i].lane];
                    1:       act = fw[tv[i].t][tv[i].lane];
                    default: act = fb[tv[i].t][tv[i].lane];
                endcase
                chk($sformatf("vec%0d_k%0d_t%0d_l%0d", i, tv[i].kind, tv[i].t, tv[i].lane), act, tv[i].exp);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lb, d0, e0, r0, t;
        tv[0]  = '{0, 0, 0, 0, 8'h01};
        tv[1]  = '{0, 0, 3, 3, 8'h00};
        tv[2]  = '{0, 0, 3, 2, 8'h00};
        tv[3]  = '{0, 0, 6, 3, 8'h01};
        tv[4]  = '{0, 0, 2, 1, 8'h01};
        tv[5]  = '{0, 0, 14, 7, 8'h01};
        tv[6]  = '{0, 0, 21, 7, 8'h00};
        tv[7]  = '{0, 1, 3, 0, 8'h04};
        tv[8]  = '{0, 1, 0, 0, 8'h01};
        tv[9]  = '{0, 1, 7, 7, 8'h01};
        tv[10] = '{0, 1, 14, 7, 8'h08};
        tv[11] = '{0, 1, 15, 7, 8'h00};
        tv[12] = '{0, 1, 2, 5, 8'h00};
        tv[13] = '{0, 1, 10, 4, 8'h07};
        tv[14] = '{1, 2, 5, 2, 8'h52};
        tv[15] = '{1, 2, 0, 0, 8'h00};
        tv[16] = '{1, 2, 7, 7, 8'h77};
        tv[17] = '{1, 2, 3, 6, 8'h36};
        tv[18] = '{1, 0, 9, 4, 8'h46};
        tv[19] = '{1, 1, 9, 2, 8'h7A};

        nrst = 1'b0; start_i = 1'b0; op_valid_i = 1'b0; bias_valid_i = 1'b0;
        op_a_i = '0; op_w_i = '0; bias_col_i = '0; sa_ov_i = 1'b0; sa_psum_i = '0; res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", any_out, 1'b0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // identity job
        set_data(0);
        d0 = done_total; e0 = err_total;
        run_load(0, lb);
        run_result(2, CN, 0);
        chk("id_feed_len", feed_pos, 22);
        chk("id_feed_start", feed_start, lb + 1);
        chk("id_bias_len", bias_pos, 8);
        apply_table(0);
        chk("id_done_once", done_total - d0, 1);
        chk("id_no_err", err_total - e0, 0);

        // interleaved load, bias replay, drain backpressure
        set_data(1);
        d0 = done_total;
        run_load(1, lb);
        run_result(1, CN, 1);
        chk("il_feed_start", feed_start, lb + 1);
        chk("il_feed_len", feed_pos, 22);
        chk("il_bias_len", bias_pos, 8);
        apply_table(1);
        chk("il_done_once", done_total - d0, 1);

        // timeout
        d0 = done_total; e0 = err_total; r0 = resv_total;
        run_load(0, lb);
        run_result(1, 0, 0);
        chk("to_err_once", err_total - e0, 1);
        chk("to_wait_cycles", wait_run, 64);
        chk("to_no_res_valid", resv_total - r0, 0);
        chk("to_no_done", done_total - d0, 0);
        chk("to_idle", busy_o, 1'b0);

        // normal job after timeout
        set_data(0);
        d0 = done_total;
        run_load(0, lb);
        run_result(3, CN, 0);
        chk("post_to_done", done_total - d0, 1);

        // result burst broken after 3 beats
        d0 = done_total; e0 = err_total;
        run_load(0, lb);
        run_result(1, 3, 0);
        chk("drop_err_once", err_total - e0, 1);
        chk("drop_no_done", done_total - d0, 0);

        // reset in FEED cycle 10
        set_data(1);
        d0 = done_total; e0 = err_total;
        run_load(0, lb);
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            if (sa_mac_iv_o) begin
                if (t == 10) break;
                t++;
            end
            @(posedge clk); #1;
        end
        chk("rst_reached_feed10", t, 10);
        nrst = 1'b0;
        #1;
        chk("rst_mid_feed_outputs", any_out, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 1'b1;
        chk("rst_no_done_err", (done_total - d0) + (err_total - e0), 0);
        @(posedge clk); #1;
        run_load(0, lb);
        run_result(2, CN, 0);
        chk("rst_new_job_done", done_total - d0, 1);
        chk("rst_new_feed_len", feed_pos, 22);
        apply_table(1);

        chk("done_err_exclusive", both_total, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
